// File: rtl/chn_fifo_arbiter.sv
// Round-robin packet drain of two channel FIFOs into the USB external FIFO.
// Each packet is one header word followed by PKT_LEN words from a single channel.
module chn_fifo_arbiter #(
  parameter int unsigned PKT_LEN = 256,
  parameter int unsigned USEDW_W = 10,
  parameter logic [3:0]  HDR_TAG = 4'hA
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rst_all_fifo,
  input  logic               arb_en,
  input  logic               chn1_fifo_empty,
  input  logic [USEDW_W-1:0] chn1_fifo_usedw,
  input  logic [15:0]        chn1_fifo_q,
  output logic               chn1_rdreq,
  input  logic               chn2_fifo_empty,
  input  logic [USEDW_W-1:0] chn2_fifo_usedw,
  input  logic [15:0]        chn2_fifo_q,
  output logic               chn2_rdreq,
  input  logic               usb_ext_fifo_afull,
  output logic [15:0]        out_to_usb_ext_fifo_din,
  output logic               out_to_usb_ext_fifo_en,
  output logic               busy,
  output logic               active_chn
);

  localparam logic [USEDW_W-1:0] PktLenW = USEDW_W'(PKT_LEN);

  typedef enum logic [2:0] {StIdle, StHdr, StBurst, StDrain0, StDrain1} state_e;

  state_e               state_q, state_d;
  logic                 active_q, active_d;
  logic                 last_q, last_d;
  logic [7:0]           seq1_q, seq1_d, seq2_q, seq2_d;
  logic [USEDW_W-1:0]   issued_q, issued_d;
  logic                 rd_d1_q, rd_d1_d;
  logic                 en_q, en_d;
  logic [15:0]          din_q, din_d;
  logic                 rdreq;
  logic                 elig1, elig2;
  logic [15:0]          q_sel;

  assign elig1 = !chn1_fifo_empty && (chn1_fifo_usedw >= PktLenW);
  assign elig2 = !chn2_fifo_empty && (chn2_fifo_usedw >= PktLenW);
  assign q_sel = active_q ? chn2_fifo_q : chn1_fifo_q;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    last_d   = last_q;
    seq1_d   = seq1_q;
    seq2_d   = seq2_q;
    issued_d = issued_q;
    rdreq    = 1'b0;
    // Data stage: q is valid the cycle after rdreq, so it is captured off rd_d1.
    en_d     = rd_d1_q;
    din_d    = rd_d1_q ? q_sel : din_q;

    unique case (state_q)
      StIdle: begin
        if (arb_en && !usb_ext_fifo_afull && (elig1 || elig2)) begin
          state_d  = StHdr;
          active_d = (elig1 && elig2) ? ~last_q : elig2;
          issued_d = '0;
        end
      end
      StHdr: begin
        en_d    = 1'b1;
        din_d   = {HDR_TAG, 3'b000, active_q, (active_q ? seq2_q : seq1_q)};
        state_d = StBurst;
      end
      StBurst: begin
        if (!usb_ext_fifo_afull && (issued_q < PktLenW)) begin
          rdreq    = 1'b1;
          issued_d = issued_q + USEDW_W'(1);
          if (issued_q == PktLenW - USEDW_W'(1)) state_d = StDrain0;
        end
      end
      StDrain0: state_d = StDrain1;
      StDrain1: begin
        state_d = StIdle;
        last_d  = active_q;
        if (active_q) seq2_d = seq2_q + 8'd1;
        else          seq1_d = seq1_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase

    rd_d1_d = rdreq;

    // Soft clear aborts any packet and drops words still in the read pipeline.
    if (rst_all_fifo) begin
      state_d  = StIdle;
      active_d = 1'b0;
      last_d   = 1'b1;
      seq1_d   = '0;
      seq2_d   = '0;
      issued_d = '0;
      rdreq    = 1'b0;
      rd_d1_d  = 1'b0;
      en_d     = 1'b0;
      din_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      active_q <= 1'b0;
      last_q   <= 1'b1;
      seq1_q   <= '0;
      seq2_q   <= '0;
      issued_q <= '0;
      rd_d1_q  <= 1'b0;
      en_q     <= 1'b0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      last_q   <= last_d;
      seq1_q   <= seq1_d;
      seq2_q   <= seq2_d;
      issued_q <= issued_d;
      rd_d1_q  <= rd_d1_d;
      en_q     <= en_d;
      din_q    <= din_d;
    end
  end

  always_comb begin
    chn1_rdreq              = rdreq & ~active_q;
    chn2_rdreq              = rdreq & active_q;
    out_to_usb_ext_fifo_en  = en_q & ~rst_all_fifo;
    out_to_usb_ext_fifo_din = din_q;
    busy                    = (state_q != StIdle);
    active_chn              = active_q;
  end

endmodule

// File: tb/tb_chn_fifo_arbiter.sv
// Bench for chn_fifo_arbiter: queue-based channel FIFO models feed the DUT and a
// packet-level model predicts channel order, header words and data order.
module tb_chn_fifo_arbiter;

  localparam int P = 16;

  logic        clk = 1'b0;
  logic        reset, rst_all_fifo, arb_en, afull_dir, rand_afull;
  logic        rnd_bit = 1'b0;
  logic        usb_afull;
  logic        chn1_fifo_empty = 1'b1, chn2_fifo_empty = 1'b1;
  logic [9:0]  chn1_fifo_usedw = '0, chn2_fifo_usedw = '0;
  logic [15:0] chn1_fifo_q = '0, chn2_fifo_q = '0;
  logic        chn1_rdreq, chn2_rdreq;
  logic [15:0] din;
  logic        en, busy, active_chn;

  always #5 clk = ~clk;
  assign usb_afull = afull_dir | (rand_afull & rnd_bit);

  chn_fifo_arbiter #(.PKT_LEN(P), .USEDW_W(10), .HDR_TAG(4'hA)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .rst_all_fifo            (rst_all_fifo),
    .arb_en                  (arb_en),
    .chn1_fifo_empty         (chn1_fifo_empty),
    .chn1_fifo_usedw         (chn1_fifo_usedw),
    .chn1_fifo_q             (chn1_fifo_q),
    .chn1_rdreq              (chn1_rdreq),
    .chn2_fifo_empty         (chn2_fifo_empty),
    .chn2_fifo_usedw         (chn2_fifo_usedw),
    .chn2_fifo_q             (chn2_fifo_q),
    .chn2_rdreq              (chn2_rdreq),
    .usb_ext_fifo_afull      (usb_afull),
    .out_to_usb_ext_fifo_din (din),
    .out_to_usb_ext_fifo_en  (en),
    .busy                    (busy),
    .active_chn              (active_chn)
  );

  // Channel FIFO models (1-cycle read latency) plus protocol monitors.
  logic [15:0] fq1[$], fq2[$];
  logic [15:0] ref1[0:8191], ref2[0:8191];
  int req1 = 0, req2 = 0, pushed1 = 0, pushed2 = 0;
  int flush1_req = 0, flush1_done = 0;
  int underrun1 = 0, underrun2 = 0, both_rd = 0, stall_viol = 0, rd2_cnt = 0;

  always @(posedge clk) begin
    if (chn1_rdreq) begin
      if (fq1.size() == 0) underrun1 <= underrun1 + 1;
      else chn1_fifo_q <= fq1.pop_front();
    end
    if (chn2_rdreq) begin
      if (fq2.size() == 0) underrun2 <= underrun2 + 1;
      else chn2_fifo_q <= fq2.pop_front();
      rd2_cnt <= rd2_cnt + 1;
    end
    if (chn1_rdreq && chn2_rdreq) both_rd <= both_rd + 1;
    if ((chn1_rdreq || chn2_rdreq) && usb_afull) stall_viol <= stall_viol + 1;
    if (flush1_req != flush1_done) begin
      fq1.delete();
      flush1_done <= flush1_req;
    end
    for (int i = pushed1; i < req1; i++) begin
      ref1[i] = 16'($urandom);
      fq1.push_back(ref1[i]);
    end
    for (int i = pushed2; i < req2; i++) begin
      ref2[i] = 16'($urandom);
      fq2.push_back(ref2[i]);
    end
    pushed1 <= req1;
    pushed2 <= req2;
    chn1_fifo_usedw <= 10'(fq1.size());
    chn2_fifo_usedw <= 10'(fq2.size());
    chn1_fifo_empty <= (fq1.size() == 0);
    chn2_fifo_empty <= (fq2.size() == 0);
  end

  logic [15:0] usb_mem[0:8191];
  int usb_wr = 0;

  always @(negedge clk) begin
    rnd_bit <= ($urandom_range(0, 3) == 0);
    if (en) begin
      usb_mem[usb_wr] <= din;
      usb_wr <= usb_wr + 1;
    end
  end

  // Packet-level reference model state.
  int total = 0, bad = 0;
  int usb_rd = 0, ref_rd1 = 0, ref_rd2 = 0;
  int avail[2];
  logic [7:0] seq_m[2];
  logic last_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic add_words(input int ch, input int n);
    if (ch == 0) req1 += n;
    else req2 += n;
    avail[ch] += n;
  endtask

  task automatic check_pkt(input logic ch, input logic [7:0] seq);
    int n = 0;
    int nbad = 0;
    logic [15:0] exp_w, got_w, first_got, first_exp;
    while ((usb_wr - usb_rd) < P + 1 && n < 50 * P + 200) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_words_arrived", 32'(usb_wr - usb_rd >= P + 1), 32'd1);
    if (usb_wr - usb_rd < P + 1) return;
    chk("pkt_header", 32'(usb_mem[usb_rd]), 32'({4'hA, 3'b000, ch, seq}));
    usb_rd++;
    first_got = '0;
    first_exp = '0;
    for (int i = 0; i < P; i++) begin
      if (ch) begin exp_w = ref2[ref_rd2]; ref_rd2++; end
      else    begin exp_w = ref1[ref_rd1]; ref_rd1++; end
      got_w = usb_mem[usb_rd];
      usb_rd++;
      if (got_w !== exp_w) begin
        if (nbad == 0) begin first_got = got_w; first_exp = exp_w; end
        nbad++;
      end
    end
    total++;
    assert (nbad === 0) else begin
      bad++;
      $error("FAIL pkt_data bad_words=%0d first got=%h want=%h", nbad, first_got, first_exp);
    end
  endtask

  // Picks the channel the round-robin rules require, then checks that packet.
  task automatic next_pkt();
    logic ch;
    if (avail[0] >= P && avail[1] >= P) ch = ~last_m;
    else ch = (avail[0] < P);
    check_pkt(ch, seq_m[ch]);
    seq_m[ch] = seq_m[ch] + 8'd1;
    last_m = ch;
    avail[ch] -= P;
  endtask

  task automatic soft_reset();
    @(negedge clk);
    rst_all_fifo = 1'b1;
    @(negedge clk);
    rst_all_fifo = 1'b0;
    seq_m[0] = '0;
    seq_m[1] = '0;
    last_m = 1'b1;
  endtask

  initial begin
    int base, n, rd2_base;
    reset = 1'b1; rst_all_fifo = 1'b0; arb_en = 1'b0; afull_dir = 1'b0; rand_afull = 1'b0;
    avail[0] = 0; avail[1] = 0; seq_m[0] = '0; seq_m[1] = '0; last_m = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({chn1_rdreq, chn2_rdreq, en, busy, active_chn, din}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'({chn1_rdreq, chn2_rdreq, en, busy}), 32'd0);

    // Single eligible channel.
    arb_en = 1'b1;
    rd2_base = rd2_cnt;
    add_words(0, P);
    next_pkt();
    repeat (4) @(negedge clk);
    chk("busy_clear_after_pkt", 32'(busy), 32'd0);
    chk("chn2_never_read", 32'(rd2_cnt - rd2_base), 32'd0);

    // Both eligible: strict alternation starting with chn1.
    arb_en = 1'b0;
    soft_reset();
    add_words(0, 2 * P);
    add_words(1, 2 * P);
    repeat (3) @(negedge clk);
    arb_en = 1'b1;
    repeat (4) next_pkt();

    // Backpressure stall mid-burst.
    base = usb_wr;
    add_words(0, P);
    n = 0;
    while (usb_wr - base < 5 && n < 200) begin @(negedge clk); n++; end
    afull_dir = 1'b1;
    repeat (2) @(negedge clk);
    chk("stall_rdreq", 32'(chn1_rdreq), 32'd0);
    repeat (3) @(negedge clk);
    afull_dir = 1'b0;
    next_pkt();
    repeat (6) @(negedge clk);
    chk("stall_en_count", 32'(usb_wr - base), 32'(P + 1));

    // Soft clear mid-packet.
    base = usb_wr;
    add_words(0, P);
    n = 0;
    while (usb_wr - base < 1 + P / 2 && n < 200) begin @(negedge clk); n++; end
    rst_all_fifo = 1'b1;
    flush1_req++;
    #1;
    chk("abort_same_cycle", 32'({chn1_rdreq, en}), 32'd0);
    @(negedge clk);
    rst_all_fifo = 1'b0;
    chk("abort_next_cycle", 32'({chn1_rdreq, chn2_rdreq, en, busy}), 32'd0);
    @(negedge clk);
    chk("abort_en_2nd_cycle", 32'(en), 32'd0);
    n = 0;
    while (flush1_done != flush1_req && n < 10) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    avail[0] = 0;
    ref_rd1 = pushed1;
    usb_rd = usb_wr;
    seq_m[0] = '0; seq_m[1] = '0; last_m = 1'b1;
    add_words(0, P);
    next_pkt();

    // Sequence byte wrap: 257 packets from chn1 after a clear.
    soft_reset();
    for (int k = 0; k < 257; k++) begin
      add_words(0, P);
      next_pkt();
    end
    chk("seq_wrapped_model", 32'(seq_m[0]), 32'd1);

    // Random backpressure with both channels loaded.
    arb_en = 1'b0;
    add_words(0, 3 * P);
    add_words(1, 3 * P);
    repeat (3) @(negedge clk);
    rand_afull = 1'b1;
    arb_en = 1'b1;
    repeat (6) next_pkt();
    rand_afull = 1'b0;

    // arb_en dropped during the header cycle.
    add_words(0, P);
    n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    chk("hdr_cycle_busy", 32'(busy), 32'd1);
    arb_en = 1'b0;
    next_pkt();
    base = usb_wr;
    add_words(0, P);
    add_words(1, P);
    repeat (4 * P) @(negedge clk);
    chk("stay_idle_busy", 32'(busy), 32'd0);
    chk("stay_idle_no_writes", 32'(usb_wr - base), 32'd0);
    arb_en = 1'b1;
    next_pkt();
    next_pkt();

    repeat (4) @(negedge clk);
    chk("no_underrun", 32'(underrun1 + underrun2), 32'd0);
    chk("no_dual_rdreq", 32'(both_rd), 32'd0);
    chk("no_rdreq_when_afull", 32'(stall_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
